axi_arbiter_2to1: RTL and testbench

AXI_ARBITER_2TO1 -- requirements
Module: axi_arbiter_2to1

---
 rtl/axi_pkg.sv | 26 ++
 rtl/axi_rr_arb2.sv | 41 ++++
 rtl/axi_arbiter_2to1.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_arbiter_2to1.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the 2:1 AXI arbiter: FSM encodings and ID widening.
// No logic; pure constants and a width helper.
// Not applicable: carries no handshakes.
package axi_pkg;

   // Write-side FSM encodings
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_ADDR = 2'd1;
   localparam logic [1:0] W_DATA = 2'd2;

   // Read-side FSM encodings
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_ADDR = 1'b1;

   // Downstream IDs carry one extra MSB naming the upstream port
   localparam int ID_EXT_BITS = 1;

   // Master 0 gets first priority out of reset
   localparam logic RESET_LAST_GRANT = 1'b1;

   // Downstream ID width for a given upstream ID width
   function automatic int ext_id_wd(input int id_wd);
      return id_wd + ID_EXT_BITS;
   endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-requester round-robin arbiter with a latched grant and last-grant register.
// Latency: grant registered on the cycle after load; last_grant updates on done.
// Backpressure: none; the caller decides when to load and when the burst is done.
module axi_rr_arb2
   import axi_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load,
   input  logic       done,
   output logic       grant,
   output logic       last_grant
);

   logic pick;

   // On a tie the requester not served last wins; otherwise the lone requester
   always_comb begin
      pick = req[1];
      if (req == 2'b11) begin
         pick = ~last_grant;
      end
   end

   // Hold the grant for the whole burst; remember who finished last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= 1'b0;
         last_grant <= RESET_LAST_GRANT;
      end else begin
         if (load && (|req)) begin
            grant <= pick;
         end
         if (done) begin
            last_grant <= grant;
         end
      end
   end

endmodule

// File: rtl/axi_arbiter_2to1.sv
// Two AXI4 masters onto one downstream port; per-channel round-robin for AW/W and AR.
// Latency: AW/AR visible downstream 1 cycle after VALID; one idle cycle between grants.
// Backpressure: downstream READYs pass to the granted master only; B/R routed by ID MSB.
module axi_arbiter_2to1
   import axi_pkg::*;
#(
   parameter int AXI_ID_WD   = 2,
   parameter int AXI_DATA_WD = 32,
   parameter int AXI_ADDR_WD = 32,
   parameter int AXI_STRB_WD = 4
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESETN,
   // upstream port 0
   input  logic [AXI_ADDR_WD-1:0] S0_AXI_AWADDR,
   input  logic [AXI_ID_WD-1:0]   S0_AXI_AWID,
   input  logic [1:0]             S0_AXI_AWBURST,
   input  logic [2:0]             S0_AXI_AWSIZE,
   input  logic [7:0]             S0_AXI_AWLEN,
   input  logic                   S0_AXI_AWVALID,
   output logic                   S0_AXI_AWREADY,
   input  logic [AXI_DATA_WD-1:0] S0_AXI_WDATA,
   input  logic [AXI_STRB_WD-1:0] S0_AXI_WSTRB,
   input  logic                   S0_AXI_WLAST,
   input  logic                   S0_AXI_WVALID,
   output logic                   S0_AXI_WREADY,
   output logic [AXI_ID_WD-1:0]   S0_AXI_BID,
   output logic [1:0]             S0_AXI_BRESP,
   output logic                   S0_AXI_BVALID,
   input  logic                   S0_AXI_BREADY,
   input  logic [AXI_ADDR_WD-1:0] S0_AXI_ARADDR,
   input  logic [AXI_ID_WD-1:0]   S0_AXI_ARID,
   input  logic [1:0]             S0_AXI_ARBURST,
   input  logic [2:0]             S0_AXI_ARSIZE,
   input  logic [7:0]             S0_AXI_ARLEN,
   input  logic                   S0_AXI_ARVALID,
   output logic                   S0_AXI_ARREADY,
   output logic [AXI_DATA_WD-1:0] S0_AXI_RDATA,
   output logic                   S0_AXI_RLAST,
   output logic [AXI_ID_WD-1:0]   S0_AXI_RID,
   output logic [1:0]             S0_AXI_RRESP,
   output logic                   S0_AXI_RVALID,
   input  logic                   S0_AXI_RREADY,
   // upstream port 1
   input  logic [AXI_ADDR_WD-1:0] S1_AXI_AWADDR,
   input  logic [AXI_ID_WD-1:0]   S1_AXI_AWID,
   input  logic [1:0]             S1_AXI_AWBURST,
   input  logic [2:0]             S1_AXI_AWSIZE,
   input  logic [7:0]             S1_AXI_AWLEN,
   input  logic                   S1_AXI_AWVALID,
   output logic                   S1_AXI_AWREADY,
   input  logic [AXI_DATA_WD-1:0] S1_AXI_WDATA,
   input  logic [AXI_STRB_WD-1:0] S1_AXI_WSTRB,
   input  logic                   S1_AXI_WLAST,
   input  logic                   S1_AXI_WVALID,
   output logic                   S1_AXI_WREADY,
   output logic [AXI_ID_WD-1:0]   S1_AXI_BID,
   output logic [1:0]             S1_AXI_BRESP,
   output logic                   S1_AXI_BVALID,
   input  logic                   S1_AXI_BREADY,
   input  logic [AXI_ADDR_WD-1:0] S1_AXI_ARADDR,
   input  logic [AXI_ID_WD-1:0]   S1_AXI_ARID,
   input  logic [1:0]             S1_AXI_ARBURST,
   input  logic [2:0]             S1_AXI_ARSIZE,
   input  logic [7:0]             S1_AXI_ARLEN,
   input  logic                   S1_AXI_ARVALID,
   output logic                   S1_AXI_ARREADY,
   output logic [AXI_DATA_WD-1:0] S1_AXI_RDATA,
   output logic                   S1_AXI_RLAST,
   output logic [AXI_ID_WD-1:0]   S1_AXI_RID,
   output logic [1:0]             S1_AXI_RRESP,
   output logic                   S1_AXI_RVALID,
   input  logic                   S1_AXI_RREADY,
   // downstream port
   output logic [AXI_ADDR_WD-1:0] M_AXI_AWADDR,
   output logic [AXI_ID_WD:0]     M_AXI_AWID,
   output logic [1:0]             M_AXI_AWBURST,
   output logic [2:0]             M_AXI_AWSIZE,
   output logic [7:0]             M_AXI_AWLEN,
   output logic                   M_AXI_AWVALID,
   input  logic                   M_AXI_AWREADY,
   output logic [AXI_DATA_WD-1:0] M_AXI_WDATA,
   output logic [AXI_STRB_WD-1:0] M_AXI_WSTRB,
   output logic                   M_AXI_WLAST,
   output logic                   M_AXI_WVALID,
   input  logic                   M_AXI_WREADY,
   input  logic [AXI_ID_WD:0]     M_AXI_BID,
   input  logic [1:0]             M_AXI_BRESP,
   input  logic                   M_AXI_BVALID,
   output logic                   M_AXI_BREADY,
   output logic [AXI_ADDR_WD-1:0] M_AXI_ARADDR,
   output logic [AXI_ID_WD:0]     M_AXI_ARID,
   output logic [1:0]             M_AXI_ARBURST,
   output logic [2:0]             M_AXI_ARSIZE,
   output logic [7:0]             M_AXI_ARLEN,
   output logic                   M_AXI_ARVALID,
   input  logic                   M_AXI_ARREADY,
   input  logic [AXI_DATA_WD-1:0] M_AXI_RDATA,
   input  logic                   M_AXI_RLAST,
   input  logic [AXI_ID_WD:0]     M_AXI_RID,
   input  logic [1:0]             M_AXI_RRESP,
   input  logic                   M_AXI_RVALID,
   output logic                   M_AXI_RREADY
);

   localparam int M_ID_WD = ext_id_wd(AXI_ID_WD);

   logic [1:0] w_state;
   logic [0:0] r_state;
   logic       wgrant, rgrant;
   logic       w_last_grant, r_last_grant;
   logic       w_load, aw_hs, w_done;
   logic       r_load, ar_hs;
   logic       in_w_addr, in_w_data, in_r_addr;
   logic       b_sel, r_sel;

   assign in_w_addr = (w_state == W_ADDR);
   assign in_w_data = (w_state == W_DATA);
   assign in_r_addr = (r_state == R_ADDR);

   assign w_load = (w_state == W_IDLE) && (S0_AXI_AWVALID || S1_AXI_AWVALID);
   assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_done = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
   assign r_load = (r_state == R_IDLE) && (S0_AXI_ARVALID || S1_AXI_ARVALID);
   assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;

   axi_rr_arb2 u_warb (
      .clk        (S_AXI_ACLK),
      .rst_n      (S_AXI_ARESETN),
      .req        ({S1_AXI_AWVALID, S0_AXI_AWVALID}),
      .load       (w_load),
      .done       (w_done),
      .grant      (wgrant),
      .last_grant (w_last_grant)
   );

   axi_rr_arb2 u_rarb (
      .clk        (S_AXI_ACLK),
      .rst_n      (S_AXI_ARESETN),
      .req        ({S1_AXI_ARVALID, S0_AXI_ARVALID}),
      .load       (r_load),
      .done       (ar_hs),
      .grant      (rgrant),
      .last_grant (r_last_grant)
   );

   // Write FSM: arbitrate, pass one AW, then the matching W burst up to WLAST
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state <= W_IDLE;
      end else begin
         case (w_state)
            W_IDLE:  if (w_load) w_state <= W_ADDR;
            W_ADDR:  if (aw_hs)  w_state <= W_DATA;
            W_DATA:  if (w_done) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: arbitrate and pass one AR; data returns by ID, not by state
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= R_IDLE;
      end else begin
         case (r_state)
            R_IDLE:  if (r_load) r_state <= R_ADDR;
            R_ADDR:  if (ar_hs)  r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // AW/W payload follows the write grant; VALIDs only leave the FSM's own state
   assign M_AXI_AWADDR   = wgrant ? S1_AXI_AWADDR  : S0_AXI_AWADDR;
   assign M_AXI_AWID     = {wgrant, (wgrant ? S1_AXI_AWID : S0_AXI_AWID)};
   assign M_AXI_AWBURST  = wgrant ? S1_AXI_AWBURST : S0_AXI_AWBURST;
   assign M_AXI_AWSIZE   = wgrant ? S1_AXI_AWSIZE  : S0_AXI_AWSIZE;
   assign M_AXI_AWLEN    = wgrant ? S1_AXI_AWLEN   : S0_AXI_AWLEN;
   assign M_AXI_AWVALID  = in_w_addr && (wgrant ? S1_AXI_AWVALID : S0_AXI_AWVALID);
   assign S0_AXI_AWREADY = in_w_addr && !wgrant && M_AXI_AWREADY;
   assign S1_AXI_AWREADY = in_w_addr &&  wgrant && M_AXI_AWREADY;

   assign M_AXI_WDATA    = wgrant ? S1_AXI_WDATA : S0_AXI_WDATA;
   assign M_AXI_WSTRB    = wgrant ? S1_AXI_WSTRB : S0_AXI_WSTRB;
   assign M_AXI_WLAST    = wgrant ? S1_AXI_WLAST : S0_AXI_WLAST;
   assign M_AXI_WVALID   = in_w_data && (wgrant ? S1_AXI_WVALID : S0_AXI_WVALID);
   assign S0_AXI_WREADY  = in_w_data && !wgrant && M_AXI_WREADY;
   assign S1_AXI_WREADY  = in_w_data &&  wgrant && M_AXI_WREADY;

   // AR payload follows the read grant
   assign M_AXI_ARADDR   = rgrant ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
   assign M_AXI_ARID     = {rgrant, (rgrant ? S1_AXI_ARID : S0_AXI_ARID)};
   assign M_AXI_ARBURST  = rgrant ? S1_AXI_ARBURST : S0_AXI_ARBURST;
   assign M_AXI_ARSIZE   = rgrant ? S1_AXI_ARSIZE  : S0_AXI_ARSIZE;
   assign M_AXI_ARLEN    = rgrant ? S1_AXI_ARLEN   : S0_AXI_ARLEN;
   assign M_AXI_ARVALID  = in_r_addr && (rgrant ? S1_AXI_ARVALID : S0_AXI_ARVALID);
   assign S0_AXI_ARREADY = in_r_addr && !rgrant && M_AXI_ARREADY;
   assign S1_AXI_ARREADY = in_r_addr &&  rgrant && M_AXI_ARREADY;

   // B/R return paths are stateless, steered by the ID MSB; held quiet while in reset
   assign b_sel = M_AXI_BID[M_ID_WD-1];
   assign r_sel = M_AXI_RID[M_ID_WD-1];

   assign S0_AXI_BID    = M_AXI_BID[AXI_ID_WD-1:0];
   assign S1_AXI_BID    = M_AXI_BID[AXI_ID_WD-1:0];
   assign S0_AXI_BRESP  = M_AXI_BRESP;
   assign S1_AXI_BRESP  = M_AXI_BRESP;
   assign S0_AXI_BVALID = S_AXI_ARESETN && M_AXI_BVALID && !b_sel;
   assign S1_AXI_BVALID = S_AXI_ARESETN && M_AXI_BVALID &&  b_sel;
   assign M_AXI_BREADY  = S_AXI_ARESETN && (b_sel ? S1_AXI_BREADY : S0_AXI_BREADY);

   assign S0_AXI_RID    = M_AXI_RID[AXI_ID_WD-1:0];
   assign S1_AXI_RID    = M_AXI_RID[AXI_ID_WD-1:0];
   assign S0_AXI_RDATA  = M_AXI_RDATA;
   assign S1_AXI_RDATA  = M_AXI_RDATA;
   assign S0_AXI_RLAST  = M_AXI_RLAST;
   assign S1_AXI_RLAST  = M_AXI_RLAST;
   assign S0_AXI_RRESP  = M_AXI_RRESP;
   assign S1_AXI_RRESP  = M_AXI_RRESP;
   assign S0_AXI_RVALID = S_AXI_ARESETN && M_AXI_RVALID && !r_sel;
   assign S1_AXI_RVALID = S_AXI_ARESETN && M_AXI_RVALID &&  r_sel;
   assign M_AXI_RREADY  = S_AXI_ARESETN && (r_sel ? S1_AXI_RREADY : S0_AXI_RREADY);

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Bench for axi_arbiter_2to1: scoreboarded AW/W/AR plus directed B/R routing.
// Drives inputs #1 after posedge, samples on negedge.
// Downstream READYs held high; grants stall only on arbitration.
module tb_axi_arbiter_2to1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // upstream side, index = port number
   logic [1:0][31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [1:0][1:0]  s_awid, s_arid, s_bid, s_rid, s_bresp, s_rresp;
   logic [1:0][7:0]  s_awlen, s_arlen;
   logic [1:0][3:0]  s_wstrb;
   logic [1:0]       s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic [1:0]       s_bvalid, s_bready, s_arvalid, s_arready;
   logic [1:0]       s_rlast, s_rvalid, s_rready;

   // downstream side
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awid, m_arid, m_bid, m_rid;
   logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
   logic [2:0]  m_awsize, m_arsize;
   logic [7:0]  m_awlen, m_arlen;
   logic [3:0]  m_wstrb;
   logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
   logic m_bvalid, m_bready, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

   axi_arbiter_2to1 dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S0_AXI_AWADDR(s_awaddr[0]), .S0_AXI_AWID(s_awid[0]), .S0_AXI_AWBURST(2'b01),
      .S0_AXI_AWSIZE(3'd2), .S0_AXI_AWLEN(s_awlen[0]), .S0_AXI_AWVALID(s_awvalid[0]),
      .S0_AXI_AWREADY(s_awready[0]), .S0_AXI_WDATA(s_wdata[0]), .S0_AXI_WSTRB(s_wstrb[0]),
      .S0_AXI_WLAST(s_wlast[0]), .S0_AXI_WVALID(s_wvalid[0]), .S0_AXI_WREADY(s_wready[0]),
      .S0_AXI_BID(s_bid[0]), .S0_AXI_BRESP(s_bresp[0]), .S0_AXI_BVALID(s_bvalid[0]),
      .S0_AXI_BREADY(s_bready[0]), .S0_AXI_ARADDR(s_araddr[0]), .S0_AXI_ARID(s_arid[0]),
      .S0_AXI_ARBURST(2'b01), .S0_AXI_ARSIZE(3'd2), .S0_AXI_ARLEN(s_arlen[0]),
      .S0_AXI_ARVALID(s_arvalid[0]), .S0_AXI_ARREADY(s_arready[0]), .S0_AXI_RDATA(s_rdata[0]),
      .S0_AXI_RLAST(s_rlast[0]), .S0_AXI_RID(s_rid[0]), .S0_AXI_RRESP(s_rresp[0]),
      .S0_AXI_RVALID(s_rvalid[0]), .S0_AXI_RREADY(s_rready[0]),
      .S1_AXI_AWADDR(s_awaddr[1]), .S1_AXI_AWID(s_awid[1]), .S1_AXI_AWBURST(2'b01),
      .S1_AXI_AWSIZE(3'd2), .S1_AXI_AWLEN(s_awlen[1]), .S1_AXI_AWVALID(s_awvalid[1]),
      .S1_AXI_AWREADY(s_awready[1]), .S1_AXI_WDATA(s_wdata[1]), .S1_AXI_WSTRB(s_wstrb[1]),
      .S1_AXI_WLAST(s_wlast[1]), .S1_AXI_WVALID(s_wvalid[1]), .S1_AXI_WREADY(s_wready[1]),
      .S1_AXI_BID(s_bid[1]), .S1_AXI_BRESP(s_bresp[1]), .S1_AXI_BVALID(s_bvalid[1]),
      .S1_AXI_BREADY(s_bready[1]), .S1_AXI_ARADDR(s_araddr[1]), .S1_AXI_ARID(s_arid[1]),
      .S1_AXI_ARBURST(2'b01), .S1_AXI_ARSIZE(3'd2), .S1_AXI_ARLEN(s_arlen[1]),
      .S1_AXI_ARVALID(s_arvalid[1]), .S1_AXI_ARREADY(s_arready[1]), .S1_AXI_RDATA(s_rdata[1]),
      .S1_AXI_RLAST(s_rlast[1]), .S1_AXI_RID(s_rid[1]), .S1_AXI_RRESP(s_rresp[1]),
      .S1_AXI_RVALID(s_rvalid[1]), .S1_AXI_RREADY(s_rready[1]),
      .M_AXI_AWADDR(m_awaddr), .M_AXI_AWID(m_awid), .M_AXI_AWBURST(m_awburst),
      .M_AXI_AWSIZE(m_awsize), .M_AXI_AWLEN(m_awlen), .M_AXI_AWVALID(m_awvalid),
      .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
      .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
      .M_AXI_BID(m_bid), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
      .M_AXI_ARADDR(m_araddr), .M_AXI_ARID(m_arid), .M_AXI_ARBURST(m_arburst),
      .M_AXI_ARSIZE(m_arsize), .M_AXI_ARLEN(m_arlen), .M_AXI_ARVALID(m_arvalid),
      .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata), .M_AXI_RLAST(m_rlast),
      .M_AXI_RID(m_rid), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
   );

   logic [63:0] aw_q[$];
   logic [63:0] w_q[$];
   logic [63:0] ar_q[$];
   int  aw_cyc = 0, ar_cyc = 0, wl_cyc = 0, aw_gap = 0, wbeats = 0;
   bit  watch_s1w = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_a(input int s, input logic [1:0] id,
                                         input logic [31:0] addr, input logic [7:0] len);
      logic sb;
      sb = (s != 0);
      return 64'({addr, len, sb, id});
   endfunction

   // expected downstream traffic for one write burst
   task automatic exp_wr(input int s, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] id, input logic [31:0] db);
      aw_q.push_back(exp_a(s, id, addr, len));
      for (int b = 0; b <= int'(len); b++) begin
         w_q.push_back(64'({(b == int'(len)), db + 32'(b)}));
      end
   endtask

   // downstream monitor: pop and compare every handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_awvalid && m_awready) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("aw", 64'({m_awaddr, m_awlen, m_awid}), aw_q.pop_front());
            aw_gap = cyc - wl_cyc;
            aw_cyc = cyc;
         end
         if (m_wvalid && m_wready) begin
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else chk("w", 64'({m_wlast, m_wdata}), w_q.pop_front());
            wbeats++;
            if (m_wlast) wl_cyc = cyc;
         end
         if (m_arvalid && m_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("ar", 64'({m_araddr, m_arlen, m_arid}), ar_q.pop_front());
            ar_cyc = cyc;
         end
         if (watch_s1w) chk("s1_wready_blocked", 64'(s_wready[1]), 0);
      end
   end

   // upstream write master; abandons the burst if reset hits
   task automatic wr(input int s, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] id, input logic [31:0] db);
      int n;
      s_awaddr[s] = addr; s_awlen[s] = len; s_awid[s] = id; s_awvalid[s] = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin s_awvalid[s] = 1'b0; return; end
         if (s_awready[s]) break;
         n++;
         if (n > 200) begin chk("aw_timeout", 1, 0); s_awvalid[s] = 1'b0; return; end
      end
      @(posedge clk); #1;
      s_awvalid[s] = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         s_wdata[s] = db + 32'(b); s_wlast[s] = (b == int'(len)); s_wvalid[s] = 1'b1;
         n = 0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin s_wvalid[s] = 1'b0; s_wlast[s] = 1'b0; return; end
            if (s_wready[s]) break;
            n++;
            if (n > 200) begin
               chk("w_timeout", 1, 0); s_wvalid[s] = 1'b0; s_wlast[s] = 1'b0; return;
            end
         end
         @(posedge clk); #1;
      end
      s_wvalid[s] = 1'b0; s_wlast[s] = 1'b0;
   endtask

   // upstream read-address master
   task automatic rd(input int s, input logic [31:0] addr, input logic [1:0] id);
      int n;
      s_araddr[s] = addr; s_arid[s] = id; s_arlen[s] = 8'd0; s_arvalid[s] = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_arready[s]) break;
         n++;
         if (n > 200) begin chk("ar_timeout", 1, 0); s_arvalid[s] = 1'b0; return; end
      end
      @(posedge clk); #1;
      s_arvalid[s] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int base, n;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_awid = '0; s_arid = '0;
      s_awlen = '0; s_arlen = '0; s_wstrb = '1; s_awvalid = '0; s_wlast = '0;
      s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
      m_rdata = '0; m_rlast = 1'b0; m_rid = '0; m_rresp = '0; m_rvalid = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_awvalid", 64'(m_awvalid), 0);
      chk("rst_m_arvalid", 64'(m_arvalid), 0);
      chk("rst_s0_awready", 64'(s_awready[0]), 0);
      chk("rst_s0_wready", 64'(s_wready[0]), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // simultaneous AW after reset: S0 first, then S1 after one idle cycle
      exp_wr(0, 32'h100, 8'd1, 2'd0, 32'hA0);
      exp_wr(1, 32'h200, 8'd1, 2'd3, 32'hB0);
      fork
         wr(0, 32'h100, 8'd1, 2'd0, 32'hA0);
         wr(1, 32'h200, 8'd1, 2'd3, 32'hB0);
      join
      chk("grant_gap", 64'(aw_gap), 2);

      // lone S0 burst: AW one cycle after VALID, 4 beats, then back to idle
      exp_wr(0, 32'h10, 8'd3, 2'd1, 32'hC0);
      fork
         wr(0, 32'h10, 8'd3, 2'd1, 32'hC0);
         begin
            @(negedge clk); chk("aw_not_yet", 64'(m_awvalid), 0);
            @(negedge clk); chk("aw_lat1", 64'(m_awvalid), 1);
         end
      join
      @(negedge clk);
      chk("idle_m_awvalid", 64'(m_awvalid), 0);
      chk("idle_m_wvalid", 64'(m_wvalid), 0);
      chk("idle_s0_wready", 64'(s_wready[0]), 0);
      @(posedge clk); #1;

      // S1 pushes W beats while S0 owns the W channel
      s_wdata[1] = 32'hDEAD; s_wlast[1] = 1'b1; s_wvalid[1] = 1'b1; watch_s1w = 1'b1;
      exp_wr(0, 32'h300, 8'd3, 2'd2, 32'hE0);
      wr(0, 32'h300, 8'd3, 2'd2, 32'hE0);
      watch_s1w = 1'b0; s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0;
      @(posedge clk); #1;

      // interleaved read returns routed by RID MSB
      s_rready = 2'b10;
      m_rvalid = 1'b1; m_rid = 3'b110; m_rdata = 32'h1111; m_rlast = 1'b1;
      @(negedge clk);
      chk("r1_s1_rvalid", 64'(s_rvalid[1]), 1);
      chk("r1_s0_rvalid", 64'(s_rvalid[0]), 0);
      chk("r1_s1_rid", 64'(s_rid[1]), 2);
      chk("r1_s1_rdata", 64'(s_rdata[1]), 64'h1111);
      chk("r1_m_rready", 64'(m_rready), 1);
      @(posedge clk); #1;
      m_rid = 3'b010; m_rdata = 32'h2222;
      @(negedge clk);
      chk("r2_s0_rvalid", 64'(s_rvalid[0]), 1);
      chk("r2_s1_rvalid", 64'(s_rvalid[1]), 0);
      chk("r2_s0_rid", 64'(s_rid[0]), 2);
      chk("r2_s0_rdata", 64'(s_rdata[0]), 64'h2222);
      chk("r2_m_rready", 64'(m_rready), 0);
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;

      // S0 write and S1 read together: independent FSMs, same cycle
      exp_wr(0, 32'h400, 8'd0, 2'd1, 32'hF0);
      ar_q.push_back(exp_a(1, 2'd2, 32'h500, 8'd0));
      fork
         wr(0, 32'h400, 8'd0, 2'd1, 32'hF0);
         rd(1, 32'h500, 2'd2);
      join
      chk("aw_ar_same_cycle", 64'(aw_cyc), 64'(ar_cyc));
      s_bready = 2'b01; s_rready = 2'b10;
      m_bvalid = 1'b1; m_bid = 3'b001; m_bresp = 2'b10;
      m_rvalid = 1'b1; m_rid = 3'b110; m_rdata = 32'h5555;
      @(negedge clk);
      chk("b_s0_bvalid", 64'(s_bvalid[0]), 1);
      chk("b_s1_bvalid", 64'(s_bvalid[1]), 0);
      chk("b_s0_bid", 64'(s_bid[0]), 1);
      chk("b_s0_bresp", 64'(s_bresp[0]), 2);
      chk("b_m_bready", 64'(m_bready), 1);
      chk("rr_s1_rvalid", 64'(s_rvalid[1]), 1);
      chk("rr_s1_rid", 64'(s_rid[1]), 2);
      @(posedge clk); #1;
      m_bid = 3'b111;
      @(negedge clk);
      chk("b_s1_bvalid", 64'(s_bvalid[1]), 1);
      chk("b_s0_off", 64'(s_bvalid[0]), 0);
      chk("b_m_bready_s1", 64'(m_bready), 0);
      @(posedge clk); #1;
      m_bid = 3'b000; m_rvalid = 1'b0;

      // reset during beat 2 of a 4-beat S0 burst
      base = wbeats;
      exp_wr(0, 32'h600, 8'd3, 2'd0, 32'h70);
      fork
         wr(0, 32'h600, 8'd3, 2'd0, 32'h70);
      join_none
      n = 0;
      while (wbeats != base + 1 && n < 200) begin @(posedge clk); n++; end
      chk("rst_wait_beat1", 64'(wbeats), 64'(base + 1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_wvalid", 64'(m_wvalid), 0);
      chk("arst_s0_wready", 64'(s_wready[0]), 0);
      chk("arst_m_awvalid", 64'(m_awvalid), 0);
      chk("arst_s0_awready", 64'(s_awready[0]), 0);
      chk("arst_s0_bvalid", 64'(s_bvalid[0]), 0);
      chk("arst_m_bready", 64'(m_bready), 0);
      repeat (3) @(posedge clk);
      aw_q.delete(); w_q.delete();
      m_bvalid = 1'b0; s_bready = '0; s_rready = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_wr(0, 32'h700, 8'd0, 2'd1, 32'h11);
      exp_wr(1, 32'h800, 8'd0, 2'd2, 32'h22);
      fork
         wr(0, 32'h700, 8'd0, 2'd1, 32'h11);
         wr(1, 32'h800, 8'd0, 2'd2, 32'h22);
      join

      repeat (2) @(posedge clk);
      chk("aw_q_left", 64'(aw_q.size()), 0);
      chk("w_q_left", 64'(w_q.size()), 0);
      chk("ar_q_left", 64'(ar_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
